// File: rtl/neorv32_fetch_pkg.sv
// Shared types and constants for the neorv32 instruction prefetch buffer.
package neorv32_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    ERR
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/neorv32_fetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries; flush overrides push and pop.
module neorv32_fetch_fifo
  import neorv32_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t       mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q;
  logic [AW-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               push_ok;
  logic               pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_ok  = pop && !empty;
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/neorv32_fetch_buffer.sv
// Instruction prefetch stage: drives the ROM address, buffers fetched words,
// and hands them to the core; redirects flush and restart sequential fetch.
module neorv32_fetch_buffer
  import neorv32_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic        fetch_err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             push, pop, flush;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     wr_entry, head;

  assign rom_addr  = fetch_pc_q;
  assign out_valid = !fifo_empty;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign fetch_err = (state_q == ERR);
  assign pop       = out_valid && out_ready;
  assign wr_entry  = '{pc: fetch_pc_q, instr: rom_data};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    flush      = 1'b0;
    if (redirect_valid) begin
      // The handshake still completes at the FIFO; flush drops everything else.
      flush = 1'b1;
      if (redirect_pc[1:0] == 2'b00) begin
        fetch_pc_d = redirect_pc;
        state_d    = RUN;
      end else begin
        state_d = ERR;
      end
    end else begin
      case (state_q)
        BOOT: state_d = RUN;
        RUN: begin
          if ((fifo_count < CNT_W'(DEPTH)) || pop) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + PC_STEP;
          end
        end
        default: state_d = ERR;
      endcase
    end
  end

  neorv32_fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst),
    .push (push),
    .pop  (pop),
    .flush(flush),
    .din  (wr_entry),
    .dout (head),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // fifo_full is implied by the count compare above; kept for visibility.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_neorv32_fetch_buffer.sv
// Scoreboard bench: stimulus queues expected {pc, instr}; monitor checks each handshake.
module tb_neorv32_fetch_buffer;
  import neorv32_fetch_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        fetch_err;

  int n_checks = 0;
  int n_fail   = 0;
  fetch_entry_t exp_q[$];

  neorv32_fetch_buffer #(
    .DEPTH(4),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_ready     (out_ready),
    .fetch_err     (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  assign rom_data = rom_word(rom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back('{pc: pc, instr: rom_word(pc)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a handshake seen at the falling edge completes at the next rising edge.
  initial begin
    fetch_entry_t e;
    forever begin
      @(negedge clk);
      if (rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_handshake_pc", out_pc, 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          check("hs_pc", out_pc, e.pc);
          check("hs_instr", out_instr, e.instr);
        end
      end
    end
  end

  initial begin
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;
    #2;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_rom_addr", rom_addr, 32'd0);

    // Streaming from reset: 8 consecutive handshakes in cycles 2..9.
    for (int k = 0; k < 8; k++) push_exp(32'(4 * k));
    @(negedge clk);
    rst = 1'b1;
    step();                                   // cycle 1
    check("boot_c1_valid", {31'b0, out_valid}, 32'd0);
    step();                                   // cycle 2
    check("boot_c2_valid", {31'b0, out_valid}, 32'd1);
    check("boot_c2_pc", out_pc, 32'h0);
    for (int k = 0; k < 7; k++) step();       // cycle 9
    step();                                   // cycle 10: async reset mid-run
    rst = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, out_valid}, 32'd0);
    check("async_rst_err", {31'b0, fetch_err}, 32'd0);
    check("async_rst_rom_addr", rom_addr, 32'd0);
    check("stream_all_delivered", exp_q.size(), 32'd0);

    // Backpressure after reset: FIFO fills, rom_addr holds 0x10.
    out_ready = 1'b0;
    for (int k = 0; k < 7; k++) push_exp(32'(4 * k));
    @(negedge clk);
    rst = 1'b1;
    step();                                   // cycle 1
    check("restart_c1_valid", {31'b0, out_valid}, 32'd0);
    step();                                   // cycle 2
    check("restart_c2_valid", {31'b0, out_valid}, 32'd1);
    check("restart_c2_pc", out_pc, 32'h0);
    check("restart_c2_instr", out_instr, 32'h1000_0000);
    for (int k = 0; k < 5; k++) step();       // cycle 7
    check("full_rom_addr", rom_addr, 32'h10);
    check("full_hold_pc", out_pc, 32'h0);
    out_ready = 1'b1;                         // handshakes 0..0x14 in cycles 7..12
    for (int k = 0; k < 6; k++) step();       // cycle 13

    // Redirect to 0x40 while full with out_ready=1: head 0x18 still handshakes.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    for (int k = 0; k < 4; k++) push_exp(32'h40 + 32'(4 * k));
    step();                                   // cycle 14
    redirect_valid = 1'b0;
    check("redir40_bubble_valid", {31'b0, out_valid}, 32'd0);
    check("redir40_rom_addr", rom_addr, 32'h40);
    step();                                   // cycle 15
    check("redir40_valid", {31'b0, out_valid}, 32'd1);
    check("redir40_pc", out_pc, 32'h40);
    step();
    step();
    step();                                   // cycle 18: misaligned redirect, head 0x4C taken
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    step();                                   // cycle 19
    redirect_valid = 1'b0;
    check("err_c1_fetch_err", {31'b0, fetch_err}, 32'd1);
    check("err_c1_valid", {31'b0, out_valid}, 32'd0);
    step();                                   // cycle 20
    check("err_c2_fetch_err", {31'b0, fetch_err}, 32'd1);
    check("err_c2_valid", {31'b0, out_valid}, 32'd0);
    check("err_rom_addr_held", rom_addr, 32'h50);
    step();                                   // cycle 21: aligned redirect recovers
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    for (int k = 0; k < 3; k++) push_exp(32'h80 + 32'(4 * k));
    step();                                   // cycle 22
    redirect_valid = 1'b0;
    check("recover_fetch_err", {31'b0, fetch_err}, 32'd0);
    check("recover_bubble_valid", {31'b0, out_valid}, 32'd0);
    check("recover_rom_addr", rom_addr, 32'h80);
    step();                                   // cycle 23
    check("recover_valid", {31'b0, out_valid}, 32'd1);
    check("recover_pc", out_pc, 32'h80);
    step();
    step();                                   // cycle 25: redirect near top of address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    push_exp(32'hFFFF_FFF8);
    push_exp(32'hFFFF_FFFC);
    push_exp(32'h0000_0000);
    push_exp(32'h0000_0004);
    step();                                   // cycle 26
    redirect_valid = 1'b0;
    check("wrap_bubble_valid", {31'b0, out_valid}, 32'd0);
    step();                                   // cycle 27
    check("wrap_pc_first", out_pc, 32'hFFFF_FFF8);
    step();
    step();
    step();
    step();                                   // cycle 31: stall, head must be 0x8
    out_ready = 1'b0;
    check("stall_valid", {31'b0, out_valid}, 32'd1);
    check("stall_pc", out_pc, 32'h8);
    step();
    check("stall_pc_hold", out_pc, 32'h8);
    check("stall_instr_hold", out_instr, 32'h1000_0002);
    check("all_expected_delivered", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
